// File: rtl/mux41_pkg.sv
// Shared constants and types for the 4-to-1 round-robin mux.
package mux41_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Last-grant pointer after reset, so that channel 0 is searched first
  localparam sel_t PTR_RST = 2'd3;

endpackage

// File: rtl/rr_arb_4.sv
// Combinational 4-way arbiter: round-robin from ptr+1, or fixed priority
// (channel 0 highest) when MUX41_FIXED_PRIO_EN is defined.
module rr_arb_4
  import mux41_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt_onehot,
  output sel_t              gnt_idx,
  output logic              gnt_any
);

  sel_t cand;
  logic found;

`ifdef MUX41_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = sel_t'(k);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end
`else
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    // 2-bit addition wraps, so k=4 lands back on ptr itself
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = ptr + sel_t'(k);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end
`endif

  assign gnt_any = en && found;

  always_comb begin
    gnt_onehot = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      gnt_onehot[i] = gnt_any && (gnt_idx == sel_t'(i));
    end
  end

endmodule

// File: rtl/mux_4_1_rr.sv
// 4-to-1 registered valid/ready mux with round-robin arbitration and source tag.
// Define MUX41_FIXED_PRIO_EN for fixed priority (channel 0 highest) instead.
module mux_4_1_rr
  import mux41_pkg::*;
#(
  parameter int DATA_W = 8
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel
);

  logic              load;
  sel_t              ptr;
  sel_t              gnt_idx;
  logic              gnt_any;
  logic [NUM_CH-1:0] gnt_onehot;
  logic [DATA_W-1:0] gnt_data;

  assign load = !out_valid || out_ready;

  // rst gates en so no handshake can be offered while reset is asserted
  rr_arb_4 u_arb (
    .req        (in_valid),
    .ptr        (ptr),
    .en         (load && !rst),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  assign in_ready = gnt_onehot;

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_onehot[i]) gnt_data = in_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef MUX41_FIXED_PRIO_EN
  assign ptr = PTR_RST;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= PTR_RST;
    else if (gnt_any) ptr <= gnt_idx;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      if (gnt_any) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_sel   <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_4_1_rr.sv
// Self-checking bench for mux_4_1_rr: directed scenarios plus random traffic
// compared against a cycle-level reference model.
module tb_mux_4_1_rr;

  localparam int DATA_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          in_valid;
  logic [3:0]          in_ready;
  logic [4*DATA_W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_sel;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_valid;
  logic [7:0]  m_data;
  int          m_sel;
  int          m_ptr;
  int          m_g;
  logic [3:0]  m_ready;
  logic [3:0]  last_hs;

  mux_4_1_rr #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
`ifdef MUX41_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) if (v[k]) return k;
`else
    for (int k = 1; k <= 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 3;
  endtask

  task automatic set_ch(input int i, input bit v, input logic [7:0] d);
    in_valid[i] = v;
    in_data[i*DATA_W +: DATA_W] = d;
  endtask

  // inputs are set at a negedge; check in_ready, clock once, check outputs
  task automatic cycle(input string tag);
    bit load;
    #1;
    load    = !m_valid || out_ready;
    m_g     = pick(in_valid, m_ptr);
    m_ready = (load && m_g >= 0) ? 4'(1 << m_g) : 4'b0;
    last_hs = m_ready & in_valid;
    check({tag, "/in_ready"}, 32'(in_ready), 32'(m_ready));
    @(posedge clk);
    if (load) begin
      if (m_g >= 0) begin
        m_valid = 1; m_data = in_data[m_g*DATA_W +: DATA_W]; m_sel = m_g; m_ptr = m_g;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    check({tag, "/out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, "/out_data"},  32'(out_data),  32'(m_data));
    check({tag, "/out_sel"},   32'(out_sel),   32'(m_sel));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; in_valid = 4'hF; in_data = '0;
    model_reset();
    last_hs = '0;
    // reset holds everything low even with requests present
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst/out_valid", 32'(out_valid), 32'd0);
      check("rst/out_data",  32'(out_data),  32'd0);
      check("rst/out_sel",   32'(out_sel),   32'd0);
      check("rst/in_ready",  32'(in_ready),  32'd0);
    end
    in_valid = '0;
    rst = 1'b0;
    cycle("idle");
    cycle("idle");

    // single channel
    set_ch(2, 1, 8'hA5);
    #1 check("single/in_ready_now", 32'(in_ready), 32'h4);
    cycle("single");
    check("single/sel2",  32'(out_sel),  32'd2);
    check("single/dataA5", 32'(out_data), 32'hA5);
    in_valid = '0;
    cycle("single_drain");

    // round robin from reset
    do_reset();
    for (int i = 0; i < 4; i++) set_ch(i, 1, 8'(8'h10 + i));
    for (int n = 0; n < 6; n++) begin
      cycle("rr");
`ifndef MUX41_FIXED_PRIO_EN
      check("rr/seq_sel",  32'(out_sel),  32'(n % 4));
      check("rr/seq_data", 32'(out_data), 32'(8'h10 + (n % 4)));
`endif
      check("rr/valid", 32'(out_valid), 32'd1);
    end

    // backpressure
    do_reset();
    in_valid = '0;
    set_ch(1, 1, 8'h3C);
    cycle("bp_load");
    set_ch(1, 0, 8'h00);
    set_ch(0, 1, 8'h55);
    set_ch(3, 1, 8'h77);
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cycle("bp_hold");
      check("bp/data3C", 32'(out_data), 32'h3C);
      check("bp/sel1",   32'(out_sel),  32'd1);
      check("bp/noready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cycle("bp_release");
`ifndef MUX41_FIXED_PRIO_EN
    check("bp/ch3_next", 32'(out_sel), 32'd3);
`endif

    // wrap-around from ptr=3
    do_reset();
    in_valid = '0;
    set_ch(3, 1, 8'hD3);
    set_ch(0, 1, 8'hD0);
    cycle("wrap0");
    check("wrap/first_ch0", 32'(out_sel), 32'd0);
    set_ch(0, 1, 8'hE0);
    cycle("wrap1");
`ifndef MUX41_FIXED_PRIO_EN
    check("wrap/then_ch3", 32'(out_sel), 32'd3);
`endif

    // async reset mid-stream
    for (int i = 0; i < 4; i++) set_ch(i, 1, 8'(8'h20 + i));
    cycle("ar_pre");
    cycle("ar_pre");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("ar/out_valid_drop", 32'(out_valid), 32'd0);
    check("ar/in_ready_zero",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle("ar_post");
    check("ar/first_sel0", 32'(out_sel), 32'd0);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (last_hs[i] || !in_valid[i]) begin
          set_ch(i, $urandom_range(1, 0) == 1, 8'($urandom));
        end else if ($urandom_range(15, 0) == 0) begin
          in_valid[i] = 1'b0;
        end
      end
      out_ready = $urandom_range(3, 0) != 0;
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
